// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with bubble insertion, stall hold and
// writeback capture so that held or loaded operands never go stale.
module id_ex_reg #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          stall,
    input  logic          flush,
    input  logic          id_valid,
    input  logic [DW-1:0] id_pc4,
    input  logic [DW-1:0] id_rs_data,
    input  logic [DW-1:0] id_rt_data,
    input  logic [DW-1:0] id_ext,
    input  logic [4:0]    id_rs,
    input  logic [4:0]    id_rt,
    input  logic [4:0]    id_rd,
    input  logic [3:0]    id_aluop,
    input  logic          id_alusrc,
    input  logic          id_regwrite,
    input  logic          id_memread,
    input  logic          id_memwrite,
    input  logic          id_memtoreg,
    input  logic [1:0]    id_regdst,
    input  logic          wb_we,
    input  logic [4:0]    wb_addr,
    input  logic [DW-1:0] wb_data,
    output logic          ex_valid,
    output logic [DW-1:0] ex_pc4,
    output logic [DW-1:0] ex_rs_data,
    output logic [DW-1:0] ex_rt_data,
    output logic [DW-1:0] ex_ext,
    output logic [4:0]    ex_rs,
    output logic [4:0]    ex_rt,
    output logic [4:0]    ex_rd,
    output logic [3:0]    ex_aluop,
    output logic          ex_alusrc,
    output logic          ex_regwrite,
    output logic          ex_memread,
    output logic          ex_memwrite,
    output logic          ex_memtoreg,
    output logic [1:0]    ex_regdst
);

    logic wb_live;
    logic hit_ex_rs;
    logic hit_ex_rt;
    logic hit_id_rs;
    logic hit_id_rt;

    // Register 0 is hardwired zero, so a write to it never forwards.
    assign wb_live   = wb_we && (wb_addr != 5'd0);
    assign hit_ex_rs = wb_live && (wb_addr == ex_rs);
    assign hit_ex_rt = wb_live && (wb_addr == ex_rt);
    assign hit_id_rs = wb_live && (wb_addr == id_rs);
    assign hit_id_rt = wb_live && (wb_addr == id_rt);

    // Control bits: cleared by flush, held on stall, gated by id_valid on load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid    <= 1'b0;
            ex_aluop    <= 4'd0;
            ex_alusrc   <= 1'b0;
            ex_regwrite <= 1'b0;
            ex_memread  <= 1'b0;
            ex_memwrite <= 1'b0;
            ex_memtoreg <= 1'b0;
            ex_regdst   <= 2'b00;
        end else if (flush) begin
            ex_valid    <= 1'b0;
            ex_aluop    <= 4'd0;
            ex_alusrc   <= 1'b0;
            ex_regwrite <= 1'b0;
            ex_memread  <= 1'b0;
            ex_memwrite <= 1'b0;
            ex_memtoreg <= 1'b0;
            ex_regdst   <= 2'b00;
        end else if (!stall) begin
            ex_valid    <= id_valid;
            ex_aluop    <= id_valid ? id_aluop : 4'd0;
            ex_alusrc   <= id_valid && id_alusrc;
            ex_regwrite <= id_valid && id_regwrite;
            ex_memread  <= id_valid && id_memread;
            ex_memwrite <= id_valid && id_memwrite;
            ex_memtoreg <= id_valid && id_memtoreg;
            ex_regdst   <= id_valid ? id_regdst : 2'b00;
        end
    end

    // Data and specifier fields: operands pick up in-flight writebacks
    // both while held and while being loaded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_pc4     <= '0;
            ex_rs_data <= '0;
            ex_rt_data <= '0;
            ex_ext     <= '0;
            ex_rs      <= 5'd0;
            ex_rt      <= 5'd0;
            ex_rd      <= 5'd0;
        end else if (flush) begin
            ex_pc4     <= '0;
            ex_rs_data <= '0;
            ex_rt_data <= '0;
            ex_ext     <= '0;
            ex_rs      <= 5'd0;
            ex_rt      <= 5'd0;
            ex_rd      <= 5'd0;
        end else if (stall) begin
            if (hit_ex_rs) ex_rs_data <= wb_data;
            if (hit_ex_rt) ex_rt_data <= wb_data;
        end else begin
            ex_pc4     <= id_pc4;
            ex_rs_data <= hit_id_rs ? wb_data : id_rs_data;
            ex_rt_data <= hit_id_rt ? wb_data : id_rt_data;
            ex_ext     <= id_ext;
            ex_rs      <= id_rs;
            ex_rt      <= id_rt;
            ex_rd      <= id_rd;
        end
    end

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed plus randomized bench for id_ex_reg with a queue scoreboard
// fed by a behavioural next-state model of the stage register.
module tb_id_ex_reg;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc4;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] ext;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [3:0]  aluop;
        logic        alusrc;
        logic        regwrite;
        logic        memread;
        logic        memwrite;
        logic        memtoreg;
        logic [1:0]  regdst;
    } st_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        id_valid = 1'b0;
    logic [31:0] id_pc4 = '0;
    logic [31:0] id_rs_data = '0;
    logic [31:0] id_rt_data = '0;
    logic [31:0] id_ext = '0;
    logic [4:0]  id_rs = '0;
    logic [4:0]  id_rt = '0;
    logic [4:0]  id_rd = '0;
    logic [3:0]  id_aluop = '0;
    logic        id_alusrc = 1'b0;
    logic        id_regwrite = 1'b0;
    logic        id_memread = 1'b0;
    logic        id_memwrite = 1'b0;
    logic        id_memtoreg = 1'b0;
    logic [1:0]  id_regdst = '0;
    logic        wb_we = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;

    logic        ex_valid;
    logic [31:0] ex_pc4;
    logic [31:0] ex_rs_data;
    logic [31:0] ex_rt_data;
    logic [31:0] ex_ext;
    logic [4:0]  ex_rs;
    logic [4:0]  ex_rt;
    logic [4:0]  ex_rd;
    logic [3:0]  ex_aluop;
    logic        ex_alusrc;
    logic        ex_regwrite;
    logic        ex_memread;
    logic        ex_memwrite;
    logic        ex_memtoreg;
    logic [1:0]  ex_regdst;

    int compared = 0;
    int mismatched = 0;
    st_t mstate = '0;
    st_t q[$];

    id_ex_reg #(.DW(32)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_pc4(id_pc4),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_ext(id_ext), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_aluop(id_aluop), .id_alusrc(id_alusrc),
        .id_regwrite(id_regwrite), .id_memread(id_memread),
        .id_memwrite(id_memwrite), .id_memtoreg(id_memtoreg),
        .id_regdst(id_regdst),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .ex_valid(ex_valid), .ex_pc4(ex_pc4),
        .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
        .ex_ext(ex_ext), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_aluop(ex_aluop), .ex_alusrc(ex_alusrc),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg),
        .ex_regdst(ex_regdst)
    );

    always #5 clk = ~clk;

    function automatic st_t observed();
        return {ex_valid, ex_pc4, ex_rs_data, ex_rt_data, ex_ext,
                ex_rs, ex_rt, ex_rd, ex_aluop, ex_alusrc, ex_regwrite,
                ex_memread, ex_memwrite, ex_memtoreg, ex_regdst};
    endfunction

    function automatic st_t model(st_t c);
        st_t n = c;
        logic live = wb_we && (wb_addr != 5'd0);
        if (flush) begin
            n = '0;
        end else if (stall) begin
            if (live && wb_addr == c.rs) n.rs_data = wb_data;
            if (live && wb_addr == c.rt) n.rt_data = wb_data;
        end else begin
            n.valid    = id_valid;
            n.pc4      = id_pc4;
            n.rs_data  = (live && wb_addr == id_rs) ? wb_data : id_rs_data;
            n.rt_data  = (live && wb_addr == id_rt) ? wb_data : id_rt_data;
            n.ext      = id_ext;
            n.rs       = id_rs;
            n.rt       = id_rt;
            n.rd       = id_rd;
            n.aluop    = id_valid ? id_aluop : 4'd0;
            n.alusrc   = id_valid & id_alusrc;
            n.regwrite = id_valid & id_regwrite;
            n.memread  = id_valid & id_memread;
            n.memwrite = id_valid & id_memwrite;
            n.memtoreg = id_valid & id_memtoreg;
            n.regdst   = id_valid ? id_regdst : 2'b00;
        end
        return n;
    endfunction

    task automatic cmp_state(input string tag, input st_t e);
        st_t o = observed();
        compared++;
        assert (o === e) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic cmp_field(input string tag, input logic [31:0] o,
                             input logic [31:0] e);
        compared++;
        assert (o === e) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    // Push the model prediction, clock once, then pop and compare.
    task automatic step(input string tag);
        st_t e;
        mstate = model(mstate);
        q.push_back(mstate);
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            compared++;
            mismatched++;
            $error("FAIL %s observed=empty expected=entry", tag);
        end else begin
            e = q.pop_front();
            cmp_state(tag, e);
        end
    endtask

    task automatic set_id(input logic v, input logic [31:0] pc4,
                          input logic [31:0] rsd, input logic [31:0] rtd,
                          input logic [31:0] ext, input logic [4:0] rs,
                          input logic [4:0] rt, input logic [4:0] rd,
                          input logic [3:0] op, input logic [4:0] ctl,
                          input logic [1:0] dst);
        id_valid   = v;
        id_pc4     = pc4;
        id_rs_data = rsd;
        id_rt_data = rtd;
        id_ext     = ext;
        id_rs      = rs;
        id_rt      = rt;
        id_rd      = rd;
        id_aluop   = op;
        {id_alusrc, id_regwrite, id_memread, id_memwrite, id_memtoreg} = ctl;
        id_regdst  = dst;
    endtask

    task automatic set_wb(input logic we, input logic [4:0] a,
                          input logic [31:0] d);
        wb_we   = we;
        wb_addr = a;
        wb_data = d;
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1;
        mstate = '0;
        cmp_state("reset_async", '0);

        set_id(1, 32'hCAFE0000, 32'h1, 32'h2, 32'h3, 5'd1, 5'd2, 5'd3,
               4'hF, 5'b11111, 2'b10);
        @(posedge clk);
        #1;
        cmp_state("reset_edge_ignored", '0);
        rst_n = 1'b1;

        set_id(1, 32'h00400004, 32'h11, 32'h22, 32'hFFFF8000, 5'd4, 5'd7,
               5'd3, 4'h6, 5'b01000, 2'b01);
        step("load_basic");
        cmp_field("load_pc4", ex_pc4, 32'h00400004);
        cmp_field("load_ext", ex_ext, 32'hFFFF8000);
        cmp_field("load_regwrite", {31'd0, ex_regwrite}, 32'd1);
        cmp_field("load_valid", {31'd0, ex_valid}, 32'd1);

        stall = 1'b1;
        flush = 1'b1;
        step("flush_and_stall");
        cmp_field("flush_valid", {31'd0, ex_valid}, 32'd0);
        cmp_field("flush_ext", ex_ext, 32'd0);
        cmp_field("flush_ctl", {27'd0, ex_regwrite, ex_memread,
                  ex_memwrite, ex_memtoreg, ex_alusrc}, 32'd0);

        stall = 1'b0;
        flush = 1'b0;
        set_id(1, 32'h00400010, 32'h11, 32'h22, 32'h44, 5'd5, 5'd6, 5'd2,
               4'h3, 5'b11111, 2'b01);
        step("load_for_stall");

        stall = 1'b1;
        set_id(1, 32'h0BAD0000, 32'h99, 32'h98, 32'h97, 5'd6, 5'd5, 5'd9,
               4'h9, 5'b00000, 2'b10);
        step("stall_c1");
        set_wb(1, 5'd5, 32'h12345678);
        step("stall_c2_capture");
        cmp_field("stall_c2_rs_data", ex_rs_data, 32'h12345678);
        set_wb(0, 5'd5, 32'h0);
        step("stall_c3_hold");
        cmp_field("stall_c3_rt_data", ex_rt_data, 32'h22);
        cmp_field("stall_c3_pc4", ex_pc4, 32'h00400010);

        stall = 1'b0;
        set_id(1, 32'h00400020, 32'h33, 32'h44, 32'h5, 5'd0, 5'd6, 5'd1,
               4'h1, 5'b01001, 2'b00);
        step("release_load");

        stall = 1'b1;
        set_wb(1, 5'd0, 32'hDEADBEEF);
        step("stall_wb_zero");
        cmp_field("stall_wb_zero_rs", ex_rs_data, 32'h33);

        stall = 1'b0;
        set_wb(0, 5'd0, 32'h0);
        set_id(1, 32'h00400030, 32'h55, 32'h66, 32'h7, 5'd8, 5'd8, 5'd2,
               4'h2, 5'b10101, 2'b01);
        step("load_same_regs");
        stall = 1'b1;
        set_wb(1, 5'd8, 32'hBEEF0008);
        step("stall_capture_both");

        flush = 1'b1;
        set_wb(1, 5'd0, 32'h77777777);
        step("flush_over_capture");

        flush = 1'b0;
        stall = 1'b0;
        set_wb(1, 5'd9, 32'hA5A5A5A5);
        set_id(1, 32'h00400040, 32'h2, 32'h1, 32'h8, 5'd4, 5'd9, 5'd9,
               4'h4, 5'b01000, 2'b00);
        step("load_fwd_rt");
        cmp_field("load_fwd_rt_data", ex_rt_data, 32'hA5A5A5A5);
        cmp_field("load_fwd_rs_data", ex_rs_data, 32'h2);

        set_wb(1, 5'd4, 32'h5A5A5A5A);
        set_id(1, 32'h00400044, 32'h3, 32'h4, 32'h9, 5'd3, 5'd4, 5'd1,
               4'h5, 5'b00110, 2'b01);
        step("load_no_capture_old_rs");

        set_wb(0, 5'd3, 32'hFFFFFFFF);
        set_id(0, 32'h00400048, 32'hAB, 32'hCD, 32'hEF, 5'd3, 5'd2, 5'd7,
               4'hA, 5'b11111, 2'b10);
        step("load_invalid_gates_ctl");
        cmp_field("invalid_ctl", {23'd0, ex_aluop, ex_regdst, ex_alusrc,
                  ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg},
                  32'd0);
        cmp_field("invalid_data", ex_rs_data, 32'hAB);

        for (int i = 0; i < 60; i++) begin
            stall = ($urandom_range(0, 2) == 0);
            flush = ($urandom_range(0, 7) == 0);
            set_wb($urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom);
            set_id($urandom_range(0, 3) != 0, $urandom, $urandom, $urandom,
                   $urandom, 5'($urandom_range(0, 7)),
                   5'($urandom_range(0, 7)), 5'($urandom),
                   4'($urandom), 5'($urandom), 2'($urandom_range(0, 2)));
            step("random");
        end

        stall = 1'b0;
        flush = 1'b0;
        set_wb(0, 5'd0, 32'h0);
        set_id(1, 32'h00400050, 32'h10, 32'h20, 32'h30, 5'd1, 5'd2, 5'd3,
               4'h7, 5'b11111, 2'b10);
        step("load_before_reset");
        stall = 1'b1;
        #3 rst_n = 1'b0;
        #1;
        mstate = '0;
        cmp_state("reset_mid_stall", '0);
        stall = 1'b0;
        @(posedge clk);
        #1;
        cmp_state("reset_held_edge", '0);
        #2 rst_n = 1'b1;
        #1;
        cmp_state("reset_released_no_edge", '0);
        set_id(1, 32'h00400060, 32'h1, 32'h2, 32'h3, 5'd1, 5'd2, 5'd3,
               4'h8, 5'b01010, 2'b01);
        step("first_load_after_reset");
        cmp_field("after_reset_pc4", ex_pc4, 32'h00400060);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
